seq_counter_prog: RTL

- Parametrised successor to the team's fixed-sequence JK counters.
- Steps through an arbitrary, run-time programmable sequence of WIDTH-bit codes held in an internal DEPTH-entry table.
- Supports forward/backward stepping, synchronous load of a sequence position, a programmable sequence length, a terminal-count pulse, and self-correction from out-of-range positions.
- Used as a stand-alone counter/sequence generator in the lab designs.

---
 rtl/seq_counter_prog.sv | 69 ++++++
 1 files changed

// File: rtl/seq_counter_prog.sv
// rtl/seq_counter_prog.sv - programmable-sequence counter stepping through a writable code table
module seq_counter_prog #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic             D,
  input  logic [IDXW-1:0]  LAST,
  input  logic             L,
  input  logic [IDXW-1:0]  LI,
  input  logic             WE,
  input  logic [IDXW-1:0]  WA,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] O,
  output logic [IDXW-1:0]  IDX,
  output logic             TC
);

  logic [WIDTH-1:0] r_table [DEPTH];
  logic [IDXW-1:0]  r_idx;
  logic             r_tc;

  logic [IDXW-1:0]  w_fwd_idx;
  logic [IDXW-1:0]  w_bwd_idx;
  logic [IDXW-1:0]  w_load_idx;
  logic             w_out_of_range;

  // An index beyond LAST (LAST lowered at run time) recovers in a single step in either direction.
  assign w_out_of_range = (r_idx > LAST);
  assign w_fwd_idx      = (r_idx >= LAST) ? '0 : r_idx + IDXW'(1);
  assign w_bwd_idx      = (r_idx == '0 || w_out_of_range) ? LAST : r_idx - IDXW'(1);
  assign w_load_idx     = (LI <= LAST) ? LI : '0;

  always_ff @(negedge C) begin
    if (R) begin
      r_idx <= '0;
      r_tc  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_table[i] <= WIDTH'(i);
      end
    end else begin
      if (WE) begin
        r_table[WA] <= WD;
      end
      if (L) begin
        r_idx <= w_load_idx;
        r_tc  <= 1'b0;
      end else if (E) begin
        if (!D) begin
          r_idx <= w_fwd_idx;
          r_tc  <= (r_idx == LAST);
        end else begin
          r_idx <= w_bwd_idx;
          r_tc  <= (r_idx == '0);
        end
      end else begin
        r_tc <= 1'b0;
      end
    end
  end

  assign O   = r_table[r_idx];
  assign IDX = r_idx;
  assign TC  = r_tc;

endmodule
